// File: rtl/adder_switch_pkg.sv
// Shared encodings for the adder switch: command opcodes, accumulate FSM states, output lane indices.
package adder_switch_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_FWD     = 3'b001,
        CMD_ADD     = 3'b010,
        CMD_VN_L    = 3'b011,
        CMD_VN_R    = 3'b100,
        CMD_VN_BOTH = 3'b101,
        CMD_ACC     = 3'b110,
        CMD_RSVD    = 3'b111
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    localparam int LANE_L = 1;
    localparam int LANE_R = 0;

endpackage

// File: rtl/adder_switch_pipe_mux.sv
// Reduction mux: the upper select bits pick the left operand from the upper half of the bus,
// the lower select bits pick the right operand from the lower half.
module reduction_mux #(
    parameter int DATA_TYPE = 24,
    parameter int NUM_IN    = 4,
    parameter int SEL_IN    = 2
) (
    input  logic [DATA_TYPE*NUM_IN-1:0] data_bus,
    input  logic [SEL_IN-1:0]           sel,
    output logic [DATA_TYPE-1:0]        sel_l,
    output logic [DATA_TYPE-1:0]        sel_r
);

    logic [DATA_TYPE-1:0] lo_words [NUM_IN/2];
    logic [DATA_TYPE-1:0] hi_words [NUM_IN/2];
    logic [SEL_IN/2-1:0]  sel_hi;
    logic [SEL_IN/2-1:0]  sel_lo;

    always_comb begin
        for (int i = 0; i < NUM_IN/2; i++) begin
            lo_words[i] = data_bus[i*DATA_TYPE +: DATA_TYPE];
            hi_words[i] = data_bus[(i+NUM_IN/2)*DATA_TYPE +: DATA_TYPE];
        end
    end

    assign sel_hi = sel[SEL_IN-1 -: SEL_IN/2];
    assign sel_lo = sel[SEL_IN/2-1:0];
    assign sel_l  = hi_words[sel_hi];
    assign sel_r  = lo_words[sel_lo];

endmodule

// File: rtl/adder_switch_pipe.sv
// Reduction-tree adder switch: mux -> add/forward/accumulate -> ADD_STAGES-deep stallable pipe.
// Define ADDER_SWITCH_SAT_EN to saturate ADD/ACC sums on carry-out and report it on o_ovf.
module adder_switch_pipe
    import adder_switch_pkg::*;
#(
    parameter int DATA_TYPE  = 24,
    parameter int NUM_IN     = 4,
    parameter int SEL_IN     = 2,
    parameter int ADD_STAGES = 2,
    parameter int ACC_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_TYPE*NUM_IN-1:0] i_data_bus,
    input  logic [SEL_IN-1:0]           i_sel,
    input  logic [2:0]                  i_cmd,
    input  logic [ACC_CNT_W-1:0]        i_acc_len,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [2*DATA_TYPE-1:0]      o_adder,
    output logic [2*DATA_TYPE-1:0]      o_vn,
    output logic [1:0]                  o_vn_valid,
    output logic                        o_ovf,
    output logic                        o_busy
);

    localparam int W = DATA_TYPE;

    logic [W-1:0] sel_l, sel_r;
    logic [W-1:0] s, t;
    logic         en, take;

    acc_state_e           state, state_n;
    logic [W-1:0]         acc, acc_n;
    logic [ACC_CNT_W-1:0] cnt, cnt_n, len, len_n, first_len, cnt_inc;

    logic         v1;
    logic [2*W-1:0] adder1, vn1;
    logic [1:0]   vnv1;

    logic           pipe_valid [ADD_STAGES];
    logic [2*W-1:0] pipe_adder [ADD_STAGES];
    logic [2*W-1:0] pipe_vn    [ADD_STAGES];
    logic [1:0]     pipe_vnv   [ADD_STAGES];

    reduction_mux #(
        .DATA_TYPE (DATA_TYPE),
        .NUM_IN    (NUM_IN),
        .SEL_IN    (SEL_IN)
    ) u_mux (
        .data_bus (i_data_bus),
        .sel      (i_sel),
        .sel_l    (sel_l),
        .sel_r    (sel_r)
    );

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign en      = !o_valid || i_ready;
    assign o_ready = en && rst;
    assign take    = i_valid && o_ready;

`ifdef ADDER_SWITCH_SAT_EN
    logic [W:0] s_raw, t_raw;
    logic       s_ovf, t_ovf, acc_sat, acc_sat_n, ovf1;
    logic       pipe_ovf [ADD_STAGES];

    always_comb begin
        s_raw = {1'b0, sel_l} + {1'b0, sel_r};
        s_ovf = s_raw[W];
        s     = s_ovf ? '1 : s_raw[W-1:0];
        t_raw = {1'b0, acc} + {1'b0, s};
        t_ovf = t_raw[W] || acc_sat;
        t     = t_ovf ? '1 : t_raw[W-1:0];
    end
`else
    assign s = sel_l + sel_r;
    assign t = acc + s;
`endif

    assign first_len = (i_acc_len == '0) ? ACC_CNT_W'(1) : i_acc_len;
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        len_n   = len;
        v1      = 1'b0;
        adder1  = '0;
        vn1     = '0;
        vnv1    = 2'b00;
`ifdef ADDER_SWITCH_SAT_EN
        acc_sat_n = acc_sat;
        ovf1      = 1'b0;
`endif
        if (take) begin
            case (cmd_e'(i_cmd))
                CMD_FWD: begin
                    v1     = 1'b1;
                    adder1 = {sel_l, sel_r};
                end
                CMD_ADD: begin
                    v1     = 1'b1;
                    adder1 = {s, s};
`ifdef ADDER_SWITCH_SAT_EN
                    ovf1   = s_ovf;
`endif
                end
                CMD_VN_L: begin
                    v1           = 1'b1;
                    vn1          = {sel_l, {W{1'b0}}};
                    vnv1[LANE_L] = 1'b1;
                    adder1       = {{W{1'b0}}, sel_r};
                end
                CMD_VN_R: begin
                    v1           = 1'b1;
                    vn1          = {{W{1'b0}}, sel_r};
                    vnv1[LANE_R] = 1'b1;
                    adder1       = {sel_l, {W{1'b0}}};
                end
                CMD_VN_BOTH: begin
                    v1   = 1'b1;
                    vn1  = {sel_l, sel_r};
                    vnv1 = 2'b11;
                end
                CMD_ACC: begin
                    if (state == ST_IDLE) begin
                        if (first_len == ACC_CNT_W'(1)) begin
                            v1     = 1'b1;
                            adder1 = {s, s};
`ifdef ADDER_SWITCH_SAT_EN
                            ovf1   = s_ovf;
`endif
                        end else begin
                            acc_n   = s;
                            cnt_n   = ACC_CNT_W'(1);
                            len_n   = first_len;
                            state_n = ST_ACCUM;
`ifdef ADDER_SWITCH_SAT_EN
                            acc_sat_n = s_ovf;
`endif
                        end
                    end else if (cnt_inc == len) begin
                        v1      = 1'b1;
                        adder1  = {t, t};
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = ST_IDLE;
`ifdef ADDER_SWITCH_SAT_EN
                        ovf1      = t_ovf;
                        acc_sat_n = 1'b0;
`endif
                    end else begin
                        acc_n = t;
                        cnt_n = cnt_inc;
`ifdef ADDER_SWITCH_SAT_EN
                        acc_sat_n = t_ovf;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
`ifdef ADDER_SWITCH_SAT_EN
            acc_sat <= 1'b0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            len   <= len_n;
`ifdef ADDER_SWITCH_SAT_EN
            acc_sat <= acc_sat_n;
`endif
        end
    end

    // Non-emitting beats load zeros, so idle stages carry all-zero lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ADD_STAGES; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_adder[i] <= '0;
                pipe_vn[i]    <= '0;
                pipe_vnv[i]   <= 2'b00;
            end
        end else if (en) begin
            pipe_valid[0] <= v1;
            pipe_adder[0] <= adder1;
            pipe_vn[0]    <= vn1;
            pipe_vnv[0]   <= vnv1;
            for (int i = 1; i < ADD_STAGES; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_adder[i] <= pipe_adder[i-1];
                pipe_vn[i]    <= pipe_vn[i-1];
                pipe_vnv[i]   <= pipe_vnv[i-1];
            end
        end
    end

`ifdef ADDER_SWITCH_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ADD_STAGES; i++) pipe_ovf[i] <= 1'b0;
        end else if (en) begin
            pipe_ovf[0] <= ovf1;
            for (int i = 1; i < ADD_STAGES; i++) pipe_ovf[i] <= pipe_ovf[i-1];
        end
    end
    assign o_ovf = pipe_ovf[ADD_STAGES-1];
`else
    assign o_ovf = 1'b0;
`endif

    assign o_valid    = pipe_valid[ADD_STAGES-1];
    assign o_adder    = pipe_adder[ADD_STAGES-1];
    assign o_vn       = pipe_vn[ADD_STAGES-1];
    assign o_vn_valid = pipe_vnv[ADD_STAGES-1];
    assign o_busy     = (state == ST_ACCUM);

endmodule

// File: tb/tb_adder_switch_pipe.sv
// Directed bench for adder_switch_pipe: hand-computed beats queued in order, checked as they leave.
module tb_adder_switch_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [95:0] i_data_bus = '0;
    logic [1:0]  i_sel = 2'b00;
    logic [2:0]  i_cmd = 3'b000;
    logic [7:0]  i_acc_len = 8'd0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [47:0] o_adder;
    logic [47:0] o_vn;
    logic [1:0]  o_vn_valid;
    logic        o_ovf;
    logic        o_busy;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef ADDER_SWITCH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [47:0] adder;
        logic [47:0] vn;
        logic [1:0]  vnv;
        logic        ovf;
    } beat_t;

    beat_t exp_q[$];

    adder_switch_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_bus (i_data_bus),
        .i_sel      (i_sel),
        .i_cmd      (i_cmd),
        .i_acc_len  (i_acc_len),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_adder    (o_adder),
        .o_vn       (o_vn),
        .o_vn_valid (o_vn_valid),
        .o_ovf      (o_ovf),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [47:0] adder, input logic [47:0] vn,
                              input logic [1:0] vnv, input logic ovf);
        beat_t b;
        b.adder = adder;
        b.vn    = vn;
        b.vnv   = vnv;
        b.ovf   = ovf;
        exp_q.push_back(b);
    endtask

    // Drives one beat starting at posedge+1 and holds it until accepted; returns at posedge+1 after acceptance.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [23:0] l, input logic [23:0] r,
                                 input logic [7:0] len, input logic [1:0] sel = 2'b00);
        int waited = 0;
        bit ok = 1'b0;
        i_valid    = 1'b1;
        i_cmd      = cmd;
        i_acc_len  = len;
        i_sel      = sel;
        i_data_bus = {sel[1] ? l : 24'hBAD003, sel[1] ? 24'hBAD002 : l,
                      sel[0] ? r : 24'hBAD001, sel[0] ? 24'hBAD000 : r};
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        i_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic waitDrain();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", {16'h0, o_adder}, 64'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                checkOutput("o_adder", 64'(o_adder), 64'(e.adder));
                checkOutput("o_vn", 64'(o_vn), 64'(e.vn));
                checkOutput("o_vn_valid", 64'(o_vn_valid), 64'(e.vnv));
                checkOutput("o_ovf", 64'(o_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        checkOutput("rst_o_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_o_ready", 64'(o_ready), 64'd0);
        checkOutput("rst_o_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_o_adder", 64'(o_adder), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        pushExpect({24'd12, 24'd12}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b010, 24'd5, 24'd7, 8'd0);
        @(negedge clk);
        checkOutput("add_lat_cycle1", 64'(o_valid), 64'd0);
        @(negedge clk);
        checkOutput("add_lat_cycle2", 64'(o_valid), 64'd1);
        @(posedge clk);
        #1;

        pushExpect(48'd0, {24'h11, 24'h22}, 2'b11, 1'b0);
        pushExpect({24'd3, 24'd4}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b101, 24'h11, 24'h22, 8'd0);
        applyStimulus(3'b001, 24'd3, 24'd4, 8'd0);
        pushExpect({24'd0, 24'hB}, {24'hA, 24'd0}, 2'b10, 1'b0);
        applyStimulus(3'b011, 24'hA, 24'hB, 8'd0);
        applyStimulus(3'b000, 24'h1, 24'h2, 8'd0);
        pushExpect({24'hA, 24'd0}, {24'd0, 24'hB}, 2'b01, 1'b0);
        applyStimulus(3'b100, 24'hA, 24'hB, 8'd0);
        applyStimulus(3'b111, 24'h3, 24'h4, 8'd0);
        pushExpect({24'h31, 24'h13}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b001, 24'h31, 24'h13, 8'd0, 2'b11);
        waitDrain();

        applyStimulus(3'b110, 24'd1, 24'd0, 8'd4);
        checkOutput("acc_busy_b1", 64'(o_busy), 64'd1);
        applyStimulus(3'b110, 24'd1, 24'd1, 8'd0);
        checkOutput("acc_busy_b2", 64'(o_busy), 64'd1);
        applyStimulus(3'b110, 24'd2, 24'd1, 8'd9);
        checkOutput("acc_busy_b3", 64'(o_busy), 64'd1);
        pushExpect({24'd10, 24'd10}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b110, 24'd3, 24'd1, 8'd0);
        checkOutput("acc_busy_done", 64'(o_busy), 64'd0);
        waitDrain();

        applyStimulus(3'b110, 24'd2, 24'd3, 8'd3);
        pushExpect({24'd10, 24'd10}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b010, 24'd9, 24'd1, 8'd0);
        checkOutput("acc_busy_after_add", 64'(o_busy), 64'd1);
        applyStimulus(3'b110, 24'd4, 24'd2, 8'd0);
        pushExpect({24'd18, 24'd18}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b110, 24'd3, 24'd4, 8'd0);
        pushExpect({24'd5, 24'd5}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b110, 24'd2, 24'd3, 8'd0);
        checkOutput("acc_len0_busy", 64'(o_busy), 64'd0);
        waitDrain();

        i_ready = 1'b0;
        pushExpect({24'd3, 24'd3}, 48'd0, 2'b00, 1'b0);
        pushExpect({24'd7, 24'd7}, 48'd0, 2'b00, 1'b0);
        pushExpect({24'd11, 24'd11}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b010, 24'd1, 24'd2, 8'd0);
        applyStimulus(3'b010, 24'd3, 24'd4, 8'd0);
        fork
            applyStimulus(3'b010, 24'd5, 24'd6, 8'd0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_o_ready", 64'(o_ready), 64'd0);
                    checkOutput("stall_o_valid", 64'(o_valid), 64'd1);
                end
                @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall_all_delivered", 64'(exp_q.size()), 64'd0);

        if (SAT) pushExpect({24'hFFFFFF, 24'hFFFFFF}, 48'd0, 2'b00, 1'b1);
        else     pushExpect({24'd1, 24'd1}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b010, 24'hFFFFFF, 24'd2, 8'd0);
        waitDrain();

        i_ready = 1'b0;
        applyStimulus(3'b110, 24'd2, 24'd2, 8'd3);
        applyStimulus(3'b010, 24'd1, 24'd1, 8'd0);
        applyStimulus(3'b010, 24'd2, 24'd2, 8'd0);
        @(negedge clk);
        checkOutput("pre_rst_busy", 64'(o_busy), 64'd1);
        checkOutput("pre_rst_valid", 64'(o_valid), 64'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(o_valid), 64'd0);
        checkOutput("async_rst_ready", 64'(o_ready), 64'd0);
        checkOutput("async_rst_busy", 64'(o_busy), 64'd0);
        checkOutput("async_rst_adder", 64'(o_adder), 64'd0);
        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", 64'(o_busy), 64'd0);
        pushExpect({24'd11, 24'd11}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b010, 24'd5, 24'd6, 8'd0);
        applyStimulus(3'b110, 24'd1, 24'd0, 8'd2);
        pushExpect({24'd2, 24'd2}, 48'd0, 2'b00, 1'b0);
        applyStimulus(3'b110, 24'd1, 24'd0, 8'd0);
        waitDrain();

        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
